// File: rtl/mw_add_seq.sv
// rtl/mw_add_seq.sv - multi-word add/subtract sequencer over one shared N-bit ripple-carry adder
// Processes one N-bit word per clock, least-significant word first, with the carry registered between words.

module rca_nb #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         co
);

  logic [n:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[n];

endmodule

module mw_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  output logic [N*WORDS-1:0] result,
  output logic               co,
  output logic               ovf,
  output logic               busy,
  output logic               done
);

  localparam int         W    = N * WORDS;
  localparam logic [3:0] LAST = 4'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic         carry;
  logic [3:0]   idx;
  logic [N-1:0] a_word;
  logic [N-1:0] b_word;
  logic [N-1:0] sum_word;
  logic         add_co;

  assign a_word = a_reg[idx*N +: N];
  assign b_word = b_reg[idx*N +: N];

  rca_nb #(.n(N)) u_rca (
    .a   (a_word),
    .b   (b_word),
    .cin (carry),
    .sum (sum_word),
    .co  (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Subtraction is a + ~b + 1: B is inverted at capture and the +1 enters as the initial carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      idx    <= 4'd0;
      result <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            idx   <= 4'd0;
          end
        end
        RUN: begin
          result[idx*N +: N] <= sum_word;
          carry              <= add_co;
          idx                <= idx + 4'd1;
          if (idx == LAST) begin
            co  <= add_co;
            ovf <= (a_word[N-1] == b_word[N-1]) && (sum_word[N-1] != a_word[N-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mw_add_seq.sv
// tb/tb_mw_add_seq.sv - directed self-checking bench for mw_add_seq
// Covers WORDS=4 and WORDS=1 instances with hand-computed vectors.

module tb_mw_add_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        co;
  logic        ovf;
  logic        busy;
  logic        done;

  logic        start1;
  logic        sub1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic [7:0]  result1;
  logic        co1;
  logic        ovf1;
  logic        busy1;
  logic        done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mw_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .result (result),
    .co     (co),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  mw_add_seq #(.N(N), .WORDS(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .sub    (sub1),
    .a      (a1),
    .b      (b1),
    .result (result1),
    .co     (co1),
    .ovf    (ovf1),
    .busy   (busy1),
    .done   (done1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    tick();
    tick();
    checks++;
    if ({result, co, ovf, busy, done} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got result=%h co=%b ovf=%b busy=%b done=%b, expected all zero",
               result, co, ovf, busy, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  // Vector table: {a, b, sub, result, co, ovf}
  task automatic test_arith;
    logic [31:0] va   [5];
    logic [31:0] vb   [5];
    logic        vs   [5];
    logic [31:0] vr   [5];
    logic        vco  [5];
    logic        vovf [5];
    va[0] = 32'hFFFFFFFF; vb[0] = 32'h00000001; vs[0] = 0; vr[0] = 32'h00000000; vco[0] = 1; vovf[0] = 0;
    va[1] = 32'h7FFFFFFF; vb[1] = 32'h00000001; vs[1] = 0; vr[1] = 32'h80000000; vco[1] = 0; vovf[1] = 1;
    va[2] = 32'h80000000; vb[2] = 32'h00000001; vs[2] = 1; vr[2] = 32'h7FFFFFFF; vco[2] = 1; vovf[2] = 1;
    va[3] = 32'h00000005; vb[3] = 32'h00000007; vs[3] = 1; vr[3] = 32'hFFFFFFFE; vco[3] = 0; vovf[3] = 0;
    va[4] = 32'h12345678; vb[4] = 32'h12345678; vs[4] = 1; vr[4] = 32'h00000000; vco[4] = 1; vovf[4] = 0;
    for (int v = 0; v < 5; v++) begin
      a = va[v]; b = vb[v]; sub = vs[v]; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~va[v]; b = ~vb[v]; sub = ~vs[v];
      for (int c = 0; c < WORDS; c++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL arith%0d_busy_c%0d: got busy=%b done=%b, expected 1 0", v, c, busy, done);
        end
        tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL arith%0d_done: got busy=%b done=%b, expected 0 1", v, busy, done);
      end
      checks++;
      if (result !== vr[v] || co !== vco[v] || ovf !== vovf[v]) begin
        errors++;
        $display("FAIL arith%0d_value: got result=%h co=%b ovf=%b, expected result=%h co=%b ovf=%b",
                 v, result, co, ovf, vr[v], vco[v], vovf[v]);
      end
      tick();
      checks++;
      if (done !== 1'b0 || result !== vr[v] || co !== vco[v] || ovf !== vovf[v]) begin
        errors++;
        $display("FAIL arith%0d_hold: got done=%b result=%h co=%b ovf=%b, expected done=0 result=%h co=%b ovf=%b",
                 v, done, result, co, ovf, vr[v], vco[v], vovf[v]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    a = 32'h01010101; b = 32'h02020202; sub = 1'b0; start = 1'b1;
    tick();
    a = 32'h10101010; b = 32'h20202020;
    dones = 0;
    for (int c = 0; c < WORDS; c++) begin
      if (done) dones++;
      tick();
    end
    checks++;
    if (done !== 1'b1 || result !== 32'h03030303) begin
      errors++;
      $display("FAIL b2b_first: got done=%b result=%h, expected done=1 result=03030303", done, result);
    end
    dones++;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_recapture: got busy=%b, expected 1", busy);
    end
    for (int c = 0; c < WORDS; c++) begin
      if (done) dones++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'h30303030) begin
      errors++;
      $display("FAIL b2b_second: got done=%b result=%h, expected done=1 result=30303030", done, result);
    end
    dones++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d done/busy events, expected 2", dones);
    end
  endtask

  task automatic test_reset_mid_run;
    int stray;
    a = 32'h11111111; b = 32'h00000001; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || result[7:0] !== 8'h12) begin
      errors++;
      $display("FAIL rst_run_pre: got busy=%b result=%h, expected busy=1 low byte 12", busy, result);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({result, co, ovf, busy, done} !== 36'd0) begin
      errors++;
      $display("FAIL rst_run_clear: got result=%h co=%b ovf=%b busy=%b done=%b, expected all zero",
               result, co, ovf, busy, done);
    end
    stray = 0;
    for (int c = 0; c < WORDS + 2; c++) begin
      tick();
      if (done || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL rst_run_no_done: got %0d busy/done cycles, expected 0", stray);
    end
    a = 32'h00FF00FF; b = 32'h00010001; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < WORDS; c++) tick();
    checks++;
    if (done !== 1'b1 || result !== 32'h01000100 || co !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_fresh: got done=%b result=%h co=%b ovf=%b, expected done=1 result=01000100 co=0 ovf=0",
               done, result, co, ovf);
    end
    tick();
  endtask

  task automatic test_words1;
    a1 = 8'hF0; b1 = 8'h20; sub1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_busy: got busy=%b done=%b, expected 1 0", busy1, done1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || result1 !== 8'h10 || co1 !== 1'b1 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_done: got done=%b busy=%b result=%h co=%b ovf=%b, expected done=1 busy=0 result=10 co=1 ovf=0",
               done1, busy1, result1, co1, ovf1);
    end
    tick();
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_idle: got done=%b busy=%b, expected 0 0", done1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid_run();
    test_words1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mw_add_seq.md
Name: mw_add_seq

Overview:
- Multi-word add/subtract sequencer built around one shared N-bit ripple-carry adder (rca_nb, instantiated with n = N).
- Computes a WORDS×N-bit sum or difference one N-bit word per clock, least-significant word first, with the carry registered between words.
- Lets wide arithmetic, e.g. 32-bit on an 8-bit adder, run without a wide adder.
- Sits between a requester, such as an ALU wrapper or a test harness, and the adder instance.

Parameters:
- N, 8, word width in bits; passed through as n of the internal rca_nb.
- WORDS, 4, number of words per operation; legal range 1..16.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request pulse or level; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; captured with operands.
- a  input  N*WORDS  operand A; captured when start is accepted.
- b  input  N*WORDS  operand B; captured when start is accepted.
- result  output  N*WORDS  sum/difference register.
- co  output  1  carry out of the most-significant word.
- ovf  output  1  two's-complement signed overflow of the full-width operation.
- busy  output  1  high while words are being processed.
- done  output  1  one-cycle completion strobe.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, word index=0, carry reg=0, result=0, co=0, ovf=0, busy=0, done=0. Reset wins over every other input, including mid-RUN; a partial result is discarded (result=0).
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge:
  - capture a into A_reg.
  - capture b into B_reg, or ~b when sub=1.
  - carry reg <= sub.
  - index <= 0; go to RUN.
  - result and co/ovf are not cleared at capture; they are overwritten word by word.
- IDLE, start=0: hold; outputs keep the last result, co and ovf.
- RUN, each cycle:
  - adder inputs: a = A_reg word[index], b = B_reg word[index], cin = carry reg.
  - at the edge: result word[index] <= sum; carry reg <= adder co; index <= index+1.
- On the edge processing word WORDS-1:
  - co <= adder co.
  - ovf <= (A msb == B' msb) && (sum msb != A msb), where B' is the possibly inverted B_reg.
  - go to DONE.
- DONE: done=1 for exactly this one cycle, busy=0; unconditional transition to IDLE. start is ignored in DONE.
- busy=1 exactly while state=RUN, including the first RUN cycle. start while busy or DONE is ignored: no recapture, no queueing.
- Latency:
  - start accepted at edge k.
  - busy high for cycles k+1..k+WORDS.
  - done high during cycle k+WORDS+1.
  - next start accepted at edge k+WORDS+2 at the earliest.
- Result validity: valid from the done cycle until the next accepted start. Intermediate words are visible during RUN and are not guaranteed meaningful.
- Subtraction semantics: co=1 means no borrow (a ≥ b unsigned).
- Arithmetic is modulo 2^(N*WORDS); no saturation.
- WORDS=1: RUN lasts one cycle; otherwise identical.
- Operand inputs a, b and sub may change freely after the capture edge without affecting the operation.
- No combinational path from any input to any output; all outputs are registered or decoded from state.

Test Plan (N=8, WORDS=4 unless stated):
- add, a=0xFFFFFFFF, b=0x00000001, start 1 cycle -> busy high 4 cycles; done on the 5th cycle after the start edge; result=0x00000000, co=1, ovf=0.
- add, a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, co=0, ovf=1. Then sub, a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, co=1, ovf=1.
- sub, a=0x00000005, b=0x00000007 -> result=0xFFFFFFFE, co=0, ovf=0. Then sub, a=b=0x12345678 -> result=0, co=1.
- Hold start=1 continuously with a=0x01010101, b=0x02020202; change a/b during RUN:
  - result=0x03030303 from the first operation.
  - second capture occurs only on the IDLE edge after DONE, and uses the new a/b.
  - exactly one done pulse per operation.
- Assert rst for 1 cycle in the 2nd RUN cycle -> next cycle state IDLE, busy=0, done=0, result=0, co=0, ovf=0; no done pulse follows. A fresh start then completes normally.
- WORDS=1: add, a=0xF0, b=0x20 -> busy 1 cycle; done next cycle; result=0x10, co=1, ovf=0.
